// File: rtl/alu_pkg.sv
// Shared types, constants and CRC4 helper for the ALU serial front end.
// Used by alu_sin_decoder and alu_sin_rx_packet.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_INV2 = 3'b010,
    OP_INV3 = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_INV6 = 3'b110,
    OP_INV7 = 3'b111
  } operation_t;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CTL  = 1'b1;

  // Bit positions inside err_out = {data, crc, op}
  localparam int unsigned ERR_DATA = 2;
  localparam int unsigned ERR_CRC  = 1;
  localparam int unsigned ERR_OP   = 0;

  localparam int unsigned CRC_MSG_W = 68;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_TYPE,
    RX_PAYLOAD,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    FR_RECV,
    FR_DROP
  } frame_state_t;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [2:0]  err;
  } record_t;

  // CRC4, x^4+x+1, init 0, MSB of msg first
  function automatic logic [3:0] crc4_generate(input logic [CRC_MSG_W-1:0] msg);
    logic [3:0] crc;
    logic       fb;
    crc = 4'h0;
    for (int i = CRC_MSG_W - 1; i >= 0; i--) begin
      fb  = crc[3] ^ msg[i];
      crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return crc;
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    case (operation_t'(op))
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sin_rx_packet.sv
// 11-bit serial deframer: start(0), type, 8 payload bits MSB first, stop(1).
// Exposes idle_c only when ALU_SIN_TIMEOUT_EN is defined.
module alu_sin_rx_packet
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
`ifdef ALU_SIN_TIMEOUT_EN
  output logic       idle_c,
`endif
  output logic       pkt_valid,
  output logic       pkt_type,
  output logic [7:0] pkt_byte,
  output logic       pkt_frame_err
);

  rx_state_t  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       type_q, type_d;
  logic       pkt_valid_d, pkt_type_d, pkt_frame_err_d;
  logic [7:0] pkt_byte_d;

`ifdef ALU_SIN_TIMEOUT_EN
  assign idle_c = (state_q == RX_IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RX_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      type_q        <= 1'b0;
      pkt_valid     <= 1'b0;
      pkt_type      <= 1'b0;
      pkt_byte      <= 8'h00;
      pkt_frame_err <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      type_q        <= type_d;
      pkt_valid     <= pkt_valid_d;
      pkt_type      <= pkt_type_d;
      pkt_byte      <= pkt_byte_d;
      pkt_frame_err <= pkt_frame_err_d;
    end
  end

  // Bit-level sequencing; the packet is published on the edge that samples stop
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    type_d          = type_q;
    pkt_valid_d     = 1'b0;
    pkt_type_d      = pkt_type;
    pkt_byte_d      = pkt_byte;
    pkt_frame_err_d = pkt_frame_err;
    case (state_q)
      RX_IDLE: begin
        if (!sin) state_d = RX_TYPE;
      end
      RX_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        shift_d   = {shift_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: begin
        pkt_valid_d     = 1'b1;
        pkt_type_d      = type_q;
        pkt_byte_d      = shift_q;
        pkt_frame_err_d = ~sin;
        state_d         = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_sin_decoder.sv
// Frame assembler/checker in front of the ALU core: 8 data + 1 ctl packet per record.
// Optional idle-gap abort of partial frames under ALU_SIN_TIMEOUT_EN.
module alu_sin_decoder
  import alu_pkg::*;
#(
  parameter int unsigned NUM_DATA_PKTS = 8
`ifdef ALU_SIN_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 100
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [2:0]  op_out,
  output logic [2:0]  err_out,
  output logic        overrun
);

  localparam int unsigned CNT_W = $clog2(NUM_DATA_PKTS + 1);
  localparam logic [CNT_W-1:0] PKTS_FULL = CNT_W'(NUM_DATA_PKTS);

  logic         pkt_valid, pkt_type, pkt_frame_err;
  logic [7:0]   pkt_byte;
  frame_state_t fr_q, fr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]  ba_q, ba_d;
  record_t      rec_q, rec_d, new_rec;
  logic         out_valid_d, overrun_d, emit;
  logic [2:0]   ctl_op;
  logic [3:0]   ctl_crc, crc_exp;

`ifdef ALU_SIN_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  logic             idle_c;
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  alu_sin_rx_packet u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .sin           (sin),
`ifdef ALU_SIN_TIMEOUT_EN
    .idle_c        (idle_c),
`endif
    .pkt_valid     (pkt_valid),
    .pkt_type      (pkt_type),
    .pkt_byte      (pkt_byte),
    .pkt_frame_err (pkt_frame_err)
  );

  assign ctl_op  = pkt_byte[6:4];
  assign ctl_crc = pkt_byte[3:0];
  assign crc_exp = crc4_generate({ba_q, 1'b1, ctl_op});

  assign b_out   = rec_q.b;
  assign a_out   = rec_q.a;
  assign op_out  = rec_q.op;
  assign err_out = rec_q.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_q      <= FR_RECV;
      cnt_q     <= '0;
      ba_q      <= 64'h0;
      rec_q     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef ALU_SIN_TIMEOUT_EN
      gap_q     <= '0;
`endif
    end else begin
      fr_q      <= fr_d;
      cnt_q     <= cnt_d;
      ba_q      <= ba_d;
      rec_q     <= rec_d;
      out_valid <= out_valid_d;
      overrun   <= overrun_d;
`ifdef ALU_SIN_TIMEOUT_EN
      gap_q     <= gap_d;
`endif
    end
  end

  always_comb begin
    fr_d        = fr_q;
    cnt_d       = cnt_q;
    ba_d        = ba_q;
    rec_d       = rec_q;
    out_valid_d = out_valid & ~out_ready;
    overrun_d   = overrun;
    emit        = 1'b0;
    new_rec.b   = ba_q[63:32];
    new_rec.a   = ba_q[31:0];
    new_rec.op  = 3'b000;
    new_rec.err = 3'b000;

    if (pkt_valid) begin
      case (fr_q)
        FR_RECV: begin
          if (pkt_type == PKT_CTL) begin
            // Error priority: data > crc > op
            emit       = 1'b1;
            new_rec.op = ctl_op;
            if (pkt_frame_err || cnt_q != PKTS_FULL) new_rec.err[ERR_DATA] = 1'b1;
            else if (ctl_crc != crc_exp)             new_rec.err[ERR_CRC]  = 1'b1;
            else if (!op_is_valid(ctl_op))           new_rec.err[ERR_OP]   = 1'b1;
            cnt_d = '0;
            ba_d  = 64'h0;
          end else if (pkt_frame_err || cnt_q == PKTS_FULL) begin
            emit                  = 1'b1;
            new_rec.err[ERR_DATA] = 1'b1;
            fr_d                  = FR_DROP;
          end else begin
            ba_d  = {ba_q[55:0], pkt_byte};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FR_DROP: begin
          // Silently swallow the rest of a failed frame up to its ctl packet
          if (pkt_type == PKT_CTL) begin
            fr_d  = FR_RECV;
            cnt_d = '0;
            ba_d  = 64'h0;
          end
        end
        default: fr_d = FR_RECV;
      endcase
    end

`ifdef ALU_SIN_TIMEOUT_EN
    gap_d = gap_q;
    if (!idle_c || !sin || (cnt_q == '0 && !pkt_valid)) begin
      gap_d = '0;
    end else if (gap_q == GAP_LAST) begin
      gap_d = '0;
      cnt_d = '0;
      ba_d  = 64'h0;
      fr_d  = FR_RECV;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end
`endif

    // A pending record accepted this cycle makes room for the new one
    if (emit) begin
      if (!out_valid || out_ready) begin
        rec_d       = new_rec;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_sin_decoder.sv
// Directed bench for alu_sin_decoder; timeout case runs only with ALU_SIN_TIMEOUT_EN.
module tb_alu_sin_decoder;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, sin, out_ready;
  logic        out_valid, overrun;
  logic [31:0] a_out, b_out;
  logic [2:0]  op_out, err_out;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  alu_sin_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .op_out    (op_out),
    .err_out   (err_out),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic t, input logic [7:0] d);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a,
                            input logic [2:0] op, input logic [3:0] crc);
    for (int i = 3; i >= 0; i--) send_pkt(PKT_DATA, b[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_pkt(PKT_DATA, a[i*8 +: 8]);
    send_pkt(PKT_CTL, {1'b0, op, crc});
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_rec(input string tag, input logic [31:0] b, input logic [31:0] a,
                           input logic [2:0] op, input logic [2:0] err);
    wait_valid(tag);
    chk({tag, "_b"}, b_out, b);
    chk({tag, "_a"}, a_out, a);
    chk({tag, "_op"}, 32'(op_out), 32'(op));
    chk({tag, "_err"}, 32'(err_out), 32'(err));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_cleared"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [3:0] crc_of(input logic [31:0] b, input logic [31:0] a,
                                        input logic [2:0] op);
    return crc4_generate({b, a, 1'b1, op});
  endfunction

  initial begin
    sin       = 1'b1;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_a", a_out, 32'd0);
    chk("rst_b", b_out, 32'd0);
    chk("rst_op", 32'(op_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-derived CRC4 reference points
    chk("crc_add21", 32'(crc4_generate({32'h2, 32'h1, 1'b1, 3'b100})), 32'hC);
    chk("crc_op011", 32'(crc4_generate({32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 3'b011})), 32'hF);

    // Good add; record held while out_ready is low
    send_frame(32'h2, 32'h1, 3'b100, 4'hC);
    check_rec("add", 32'h2, 32'h1, 3'b100, 3'b000);
    idle(4);
    chk("add_held", 32'(out_valid), 32'd1);
    chk("add_held_b", b_out, 32'h2);
    accept("add");

    // Short frame: 7 data packets then ctl
    for (int i = 1; i <= 7; i++) send_pkt(PKT_DATA, 8'(i));
    send_pkt(PKT_CTL, {1'b0, 3'b100, 4'h0});
    check_rec("short", 32'h0001_0203, 32'h0405_0607, 3'b100, 3'b100);
    accept("short");
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, crc_of(32'h1234_5678, 32'h9ABC_DEF0, 3'b001));
    check_rec("after_short", 32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 3'b000);
    accept("after_short");

    // CRC errors, including CRC beating a bad opcode
    send_frame(32'h2, 32'h1, 3'b100, 4'hD);
    check_rec("crc_bad", 32'h2, 32'h1, 3'b100, 3'b010);
    accept("crc_bad");
    send_frame(32'h2, 32'h1, 3'b111, 4'hC);
    check_rec("crc_prio", 32'h2, 32'h1, 3'b111, 3'b010);
    accept("crc_prio");

    // Unsupported opcode with correct CRC
    send_frame(32'h8000_0000, 32'hFFFF_FFFF, 3'b011, 4'hF);
    check_rec("op_bad", 32'h8000_0000, 32'hFFFF_FFFF, 3'b011, 3'b001);
    accept("op_bad");

    // Ninth data packet: one error record, trailing ctl swallowed
    for (int i = 1; i <= 9; i++) send_pkt(PKT_DATA, 8'(i * 17));
    wait_valid("ninth");
    chk("ninth_err", 32'(err_out), 32'h4);
    chk("ninth_b", b_out, 32'h1122_3344);
    chk("ninth_a", a_out, 32'h5566_7788);
    accept("ninth");
    send_pkt(PKT_CTL, {1'b0, 3'b100, 4'h0});
    idle(5);
    chk("drop_norec", 32'(out_valid), 32'd0);
    send_frame(32'h5, 32'h3, 3'b101, crc_of(32'h5, 32'h3, 3'b101));
    check_rec("after_drop", 32'h5, 32'h3, 3'b101, 3'b000);
    accept("after_drop");

    // Ready arrives on the very edge the next record loads: no overrun
    send_frame(32'h2, 32'h1, 3'b100, 4'hC);
    wait_valid("pend");
    send_frame(32'h7, 32'h9, 3'b000, crc_of(32'h7, 32'h9, 3'b000));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_rec("swap", 32'h7, 32'h9, 3'b000, 3'b000);
    chk("swap_overrun", 32'(overrun), 32'd0);
    accept("swap");

    // Two frames with no consumer: first kept, overrun sticks
    send_frame(32'h2, 32'h1, 3'b100, 4'hC);
    send_frame(32'h5, 32'h3, 3'b101, crc_of(32'h5, 32'h3, 3'b101));
    idle(3);
    check_rec("ovr", 32'h2, 32'h1, 3'b100, 3'b000);
    chk("ovr_flag", 32'(overrun), 32'd1);

    // Asynchronous reset in the middle of a packet
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_a", a_out, 32'd0);
    chk("arst_b", b_out, 32'd0);
    chk("arst_op", 32'(op_out), 32'd0);
    chk("arst_err", 32'(err_out), 32'd0);
    sin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(32'hDEAD_BEEF, 32'h0000_00FF, 3'b100, crc_of(32'hDEAD_BEEF, 32'h0000_00FF, 3'b100));
    check_rec("post_rst", 32'hDEAD_BEEF, 32'h0000_00FF, 3'b100, 3'b000);
    chk("post_rst_overrun", 32'(overrun), 32'd0);
    accept("post_rst");

`ifdef ALU_SIN_TIMEOUT_EN
    // Partial frame abandoned after an idle gap
    for (int i = 1; i <= 3; i++) send_pkt(PKT_DATA, 8'(i));
    idle(100);
    send_frame(32'h2, 32'h1, 3'b100, 4'hC);
    check_rec("tmo", 32'h2, 32'h1, 3'b100, 3'b000);
    accept("tmo");
    idle(20);
    chk("tmo_single", 32'(out_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
